// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- top-level game sequencer.
//
// Runs the IDLE -> RUN -> CRASH -> (RUN | OVER) -> IDLE game flow, generates
// the slow/fast playfield update ticks, the obstacle drop pulse, keeps score,
// lives and speed level, and drives the crash flash indicator.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   start        in   start button level (debounced upstream)
//   colision     in   collision flag from the playfield
//   upsig        out  one-cycle slow update tick, only while RUN
//   upsig_fast   out  one-cycle fast update tick, only while RUN
//   drop         out  one-cycle obstacle spawn pulse, only while RUN
//   respawn      out  one-cycle pulse on the CRASH -> RUN transition
//   flash        out  crash flash indicator
//   state        out  00 IDLE, 01 RUN, 10 CRASH, 11 OVER
//   total_score  out  current score (saturating)
//   lives        out  remaining lives
//   level        out  current speed level
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int          SLOW_DIV     = 131072,
    parameter int          FAST_DIV     = 65536,
    parameter int          SCORE_PERIOD = 50000000,
    parameter int          SCORE_W      = 8,
    parameter int          LIVES        = 3,
    parameter int          CRASH_TICKS  = 16,
    parameter logic [25:0] DROP_BASE    = 26'd13286389,
    parameter logic [25:0] DROP_STEP    = 26'd1000000,
    parameter int          LEVEL_PTS    = 10,
    parameter int          MAX_LEVEL    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               colision,
    output logic               upsig,
    output logic               upsig_fast,
    output logic               drop,
    output logic               respawn,
    output logic               flash,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] total_score,
    output logic [2:0]         lives,
    output logic [2:0]         level
);

    localparam int SLW = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
    localparam int FSW = (FAST_DIV > 2) ? $clog2(FAST_DIV) : 1;
    localparam int SCW = (SCORE_PERIOD > 2) ? $clog2(SCORE_PERIOD) : 1;
    localparam int TCW = $clog2(CRASH_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [SLW-1:0]     slow_q, slow_d;
    logic [FSW-1:0]     fast_q, fast_d;
    logic [SCW-1:0]     score_cnt_q, score_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         level_q, level_d;
    logic [25:0]        drop_cnt_q, drop_cnt_d;
    logic [2:0]         lives_q, lives_d;
    logic               flash_q, flash_d;
    logic [TCW-1:0]     tcnt_q, tcnt_d;
    logic               start_q;
    logic               arm_q, arm_d;

    logic               slow_tick, fast_tick, score_wrap, drop_term;
    logic               drop_now, respawn_now;
    logic [31:0]        dec, period;

    function automatic logic [2:0] calc_level(input logic [SCORE_W-1:0] s);
        int l;
        l = 32'(s) / LEVEL_PTS;
        if (l > MAX_LEVEL) l = MAX_LEVEL;
        return 3'(l);
    endfunction

    // Free-running dividers; the tick is the wrap cycle itself.
    assign slow_tick = (slow_q == SLW'(SLOW_DIV - 1));
    assign fast_tick = (fast_q == FSW'(FAST_DIV - 1));
    assign slow_d    = slow_tick ? '0 : slow_q + 1'b1;
    assign fast_d    = fast_tick ? '0 : fast_q + 1'b1;

    assign score_wrap = (score_cnt_q == SCW'(SCORE_PERIOD - 1));

    // Drop period shrinks per level but never below one DROP_STEP. Using >=
    // means a level change that lands past the new terminal count fires at once.
    assign dec       = 32'(level_q) * 32'(DROP_STEP);
    assign period    = (32'(DROP_BASE) > dec + 32'(DROP_STEP)) ? 32'(DROP_BASE) - dec
                                                                : 32'(DROP_STEP);
    assign drop_term = (32'(drop_cnt_q) >= period - 32'd1);

    always_comb begin
        state_d     = state_q;
        score_cnt_d = score_cnt_q;
        score_d     = score_q;
        level_d     = calc_level(score_q);
        drop_cnt_d  = drop_cnt_q;
        lives_d     = lives_q;
        tcnt_d      = tcnt_q;
        arm_d       = arm_q;
        drop_now    = 1'b0;
        respawn_now = 1'b0;

        // IDLE only starts a game once start has been seen low since OVER.
        if (!start) arm_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start && arm_q) begin
                    state_d     = RUN;
                    lives_d     = 3'(LIVES);
                    score_d     = '0;
                    level_d     = '0;
                    score_cnt_d = '0;
                    drop_cnt_d  = '0;
                end
            end
            RUN: begin
                if (colision) begin
                    // Collision wins: counters freeze, no drop this cycle.
                    state_d = CRASH;
                    tcnt_d  = '0;
                end else begin
                    score_cnt_d = score_wrap ? '0 : score_cnt_q + 1'b1;
                    if (score_wrap && (score_q != '1)) score_d = score_q + 1'b1;
                    if (drop_term) begin
                        drop_now   = 1'b1;
                        drop_cnt_d = '0;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            CRASH: begin
                // Lives drop exactly once, on the tick that completes the count;
                // the count then sticks until the playfield is clear.
                if (slow_tick && (tcnt_q == TCW'(CRASH_TICKS - 1))) begin
                    tcnt_d  = TCW'(CRASH_TICKS);
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) state_d = OVER;
                end else if ((tcnt_q == TCW'(CRASH_TICKS)) && !colision) begin
                    state_d     = RUN;
                    respawn_now = 1'b1;
                end else if (slow_tick && (tcnt_q < TCW'(CRASH_TICKS))) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            OVER: begin
                if (start && !start_q) begin
                    state_d = IDLE;
                    arm_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        flash_d = 1'b0;
        if (state_d == CRASH) begin
            flash_d = (state_q != CRASH) ? 1'b1 : (slow_tick ? ~flash_q : flash_q);
        end else if (state_d == OVER) begin
            flash_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            slow_q      <= '0;
            fast_q      <= '0;
            score_cnt_q <= '0;
            score_q     <= '0;
            level_q     <= '0;
            drop_cnt_q  <= '0;
            lives_q     <= '0;
            flash_q     <= 1'b0;
            tcnt_q      <= '0;
            start_q     <= 1'b0;
            arm_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            slow_q      <= slow_d;
            fast_q      <= fast_d;
            score_cnt_q <= score_cnt_d;
            score_q     <= score_d;
            level_q     <= level_d;
            drop_cnt_q  <= drop_cnt_d;
            lives_q     <= lives_d;
            flash_q     <= flash_d;
            tcnt_q      <= tcnt_d;
            start_q     <= start;
            arm_q       <= arm_d;
        end
    end

    assign upsig       = slow_tick && (state_q == RUN);
    assign upsig_fast  = fast_tick && (state_q == RUN);
    assign drop        = drop_now;
    // A reset landing on the exit cycle must not leak a respawn pulse.
    assign respawn     = respawn_now && reset;
    assign flash       = flash_q;
    assign state       = state_q;
    assign total_score = score_q;
    assign lives       = lives_q;
    assign level       = level_q;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       colision;
    logic       upsig, upsig_fast, drop, respawn, flash;
    logic [1:0] state;
    logic [3:0] total_score;
    logic [2:0] lives, level;

    game_ctrl #(
        .SLOW_DIV(8), .FAST_DIV(4), .SCORE_PERIOD(20), .SCORE_W(4), .LIVES(2),
        .CRASH_TICKS(2), .DROP_BASE(26'd30), .DROP_STEP(26'd5), .LEVEL_PTS(2),
        .MAX_LEVEL(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .colision(colision),
        .upsig(upsig), .upsig_fast(upsig_fast), .drop(drop), .respawn(respawn),
        .flash(flash), .state(state), .total_score(total_score), .lives(lives),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;
    int sc   = 0;       // model of the slow divider value in the current row
    logic prev_r = 1'b0;

    typedef struct {
        logic r, s, c, chk;
        int   st, lv, up, upf;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        nchk++;
        if (act !== 32'(exp)) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One row: at the falling edge, advance the divider model for the rising
    // edge just passed, drive new inputs, then let outputs settle.
    task automatic step(input logic r, input logic s, input logic c);
        @(negedge clk);
        if (!prev_r) sc = 0;
        else         sc = (sc == 7) ? 0 : sc + 1;
        reset = r; start = s; colision = c;
        prev_r = r;
        #1;
    endtask

    function automatic vec_t mk(input logic r, s, c, k, input int st, lv, up, upf);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.chk = k;
        v.st = st; v.lv = lv; v.up = up; v.upf = upf;
        return v;
    endfunction

    int   first_d, prev_d, last_d, mono_err, fl, ticks, exp_l;
    logic [3:0] prev_score;

    initial begin
        reset = 1'b0; start = 1'b0; colision = 1'b0;

        // Reset, start, then the first divider ticks in RUN.
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        tbl[2] = mk(1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 3; i < 18; i++) tbl[i] = mk(1, 0, 0, 1, 1, 2, 0, 0);
        tbl[5].upf  = 1;
        tbl[9].up   = 1; tbl[9].upf  = 1;
        tbl[13].upf = 1;
        tbl[17].up  = 1; tbl[17].upf = 1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].c);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_state", i), state, tbl[i].st);
                chk($sformatf("v%0d_lives", i), lives, tbl[i].lv);
                chk($sformatf("v%0d_score", i), total_score, 0);
                chk($sformatf("v%0d_level", i), level, 0);
                chk($sformatf("v%0d_flash", i), flash, 0);
                chk($sformatf("v%0d_upsig", i), upsig, tbl[i].up);
                chk($sformatf("v%0d_upfast", i), upsig_fast, tbl[i].upf);
                chk($sformatf("v%0d_drop", i), drop, 0);
                chk($sformatf("v%0d_respawn", i), respawn, 0);
            end
        end

        // Long run: score every 20 cycles, level capped at 3, saturation at 15.
        first_d = -1; prev_d = -1; last_d = -1; mono_err = 0;
        prev_score = total_score;
        for (int k = 18; k <= 403; k++) begin
            step(1, 0, 0);
            if (drop) begin
                if (first_d < 0) first_d = k;
                if (k >= 150) begin prev_d = last_d; last_d = k; end
            end
            if (total_score < prev_score) mono_err++;
            prev_score = total_score;
            if (k == 203) begin
                chk("score_200", total_score, 10);
                chk("level_200", level, 3);
            end
            if (k == 403) begin
                chk("score_sat", total_score, 15);
                chk("level_sat", level, 3);
            end
        end
        chk("score_nowrap", mono_err, 0);
        chk("first_drop_row", first_d, 32);
        chk("drop_interval_l3", last_d - prev_d, 15);

        // Fresh game for the crash sequences.
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 0);
        chk("rst_score_clr", total_score, 0);
        chk("rst_level_clr", level, 0);
        step(1, 0, 0);
        chk("g2_state", state, 1);
        for (int k = 4; k <= 21; k++) step(1, 0, 0);
        step(1, 0, 1);                       // collision on the score-wrap cycle
        chk("col_wrap_state", state, 1);
        chk("col_wrap_drop", drop, 0);

        fl = 1; ticks = 0; exp_l = 2;
        for (int k = 23; k <= 42; k++) begin
            step(1, 0, 1);
            chk($sformatf("c1_%0d_state", k), state, 2);
            chk($sformatf("c1_%0d_flash", k), flash, fl);
            chk($sformatf("c1_%0d_lives", k), lives, exp_l);
            chk($sformatf("c1_%0d_score", k), total_score, 0);
            chk($sformatf("c1_%0d_respawn", k), respawn, 0);
            if (sc == 7) begin
                fl = 1 - fl;
                ticks++;
                if (ticks == 2) exp_l = 1;
            end
        end
        step(1, 0, 0);
        chk("c1_respawn_pulse", respawn, 1);
        chk("c1_exit_state", state, 2);
        step(1, 0, 0);
        chk("c1_run_state", state, 1);
        chk("c1_respawn_one", respawn, 0);
        chk("c1_run_flash", flash, 0);
        chk("c1_run_lives", lives, 1);
        chk("c1_score_held", total_score, 0);
        step(1, 0, 0);
        chk("c1_score_resume", total_score, 1);

        // Second crash ends the game; start is held high throughout.
        step(1, 1, 1);
        chk("c2_pre_state", state, 1);
        fl = 1;
        for (int k = 47; k <= 57; k++) begin
            step(1, 1, 0);
            chk($sformatf("c2_%0d_state", k), state, 2);
            chk($sformatf("c2_%0d_flash", k), flash, fl);
            chk($sformatf("c2_%0d_respawn", k), respawn, 0);
            if (sc == 7) fl = 1 - fl;
        end
        step(1, 1, 0);
        chk("over_state", state, 3);
        chk("over_lives", lives, 0);
        chk("over_flash", flash, 1);
        chk("over_score", total_score, 1);
        for (int k = 59; k <= 61; k++) begin
            step(1, 1, 0);
            chk($sformatf("over_hold_%0d", k), state, 3);
        end
        step(1, 0, 0);
        chk("over_low", state, 3);
        step(1, 1, 0);
        chk("over_edge", state, 3);
        step(1, 1, 0);
        chk("idle_state", state, 0);
        chk("idle_flash", flash, 0);
        for (int k = 65; k <= 66; k++) begin
            step(1, 1, 0);
            chk($sformatf("idle_noretrig_%0d", k), state, 0);
        end
        step(1, 0, 0);
        chk("idle_low", state, 0);
        step(1, 1, 0);
        chk("idle_edge", state, 0);
        step(1, 0, 0);
        chk("g3_state", state, 1);
        chk("g3_lives", lives, 2);
        chk("g3_score", total_score, 0);

        // Reset lands on what would be the respawn cycle.
        step(1, 0, 1);
        ticks = 0;
        for (int k = 71; k <= 90; k++) begin
            step(1, 0, 1);
            chk($sformatf("c3_%0d_state", k), state, 2);
            chk($sformatf("c3_%0d_respawn", k), respawn, 0);
            if (sc == 7) ticks++;
        end
        chk("c3_ticks_seen", ticks, 3);
        step(0, 0, 0);
        chk("c3_rst_respawn", respawn, 0);
        chk("c3_rst_lives", lives, 1);
        step(1, 0, 0);
        chk("c3_after_state", state, 0);
        chk("c3_after_lives", lives, 0);
        chk("c3_after_flash", flash, 0);
        chk("c3_after_score", total_score, 0);
        chk("c3_after_respawn", respawn, 0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
